// File: rtl/calendar_counter.sv
// Day/month/year calendar counter with leap-year handling and validated loads.
// One selected field is driven onto a gated databus for the display mux.
module calendar_counter #(
  parameter int YEAR_W    = 12,
  parameter int YEAR_INIT = 2000,
  parameter int LEAP_MODE = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              tick,
  input  logic              load,
  input  logic [4:0]        ld_day,
  input  logic [3:0]        ld_month,
  input  logic [YEAR_W-1:0] ld_year,
  input  logic              enable,
  input  logic [1:0]        sel,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [YEAR_W-1:0] databus,
  output logic              new_year,
  output logic              load_err
);

  logic [4:0]        r_day;
  logic [3:0]        r_month;
  logic [YEAR_W-1:0] r_year;
  logic              r_new_year;
  logic              r_load_err;

  logic [4:0]        w_ml;
  logic [4:0]        w_ld_ml;
  logic              w_ld_ok;
  logic              w_month_end;
  logic              w_year_end;
  logic [YEAR_W-1:0] w_bus;

  function automatic logic f_leap(input logic [YEAR_W-1:0] y);
    logic [31:0] v;
    v = 32'(y);
    if (LEAP_MODE == 0) return v[1:0] == 2'b00;
    return (v[1:0] == 2'b00) &&
           (((v % 32'd100) != 32'd0) || ((v % 32'd400) == 32'd0));
  endfunction

  function automatic logic [4:0] f_ml(input logic [3:0] m,
                                      input logic       leap);
    case (m)
      4'd2:                   return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      default:                return 5'd31;
    endcase
  endfunction

  assign w_ml    = f_ml(r_month, f_leap(r_year));
  assign w_ld_ml = f_ml(ld_month, f_leap(ld_year));

  assign w_ld_ok = (ld_month >= 4'd1) && (ld_month <= 4'd12) &&
                   (ld_day >= 5'd1) && (ld_day <= w_ld_ml);

  // >= rather than == keeps the counter self-correcting
  assign w_month_end = r_day >= w_ml;
  assign w_year_end  = r_month >= 4'd12;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_day      <= 5'd1;
      r_month    <= 4'd1;
      r_year     <= YEAR_W'(YEAR_INIT);
      r_new_year <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_new_year <= 1'b0;
      if (load) begin
        if (w_ld_ok) begin
          r_day      <= ld_day;
          r_month    <= ld_month;
          r_year     <= ld_year;
          r_load_err <= 1'b0;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (tick) begin
        if (!w_month_end) begin
          r_day <= r_day + 5'd1;
        end else if (!w_year_end) begin
          r_day   <= 5'd1;
          r_month <= r_month + 4'd1;
        end else begin
          r_day      <= 5'd1;
          r_month    <= 4'd1;
          r_year     <= r_year + YEAR_W'(1);
          r_new_year <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_bus = '0;
    if (enable) begin
      case (sel)
        2'd0:    w_bus = YEAR_W'(r_day);
        2'd1:    w_bus = YEAR_W'(r_month);
        2'd2:    w_bus = r_year;
        default: w_bus = '0;
      endcase
    end
  end

  assign day      = r_day;
  assign month    = r_month;
  assign year     = r_year;
  assign databus  = w_bus;
  assign new_year = r_new_year;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_calendar_counter.sv
// Scoreboard bench for calendar_counter: Gregorian, div-4 and 4-bit-year
// instances share stimulus; expectations are queued and checked by a monitor.
module tb_calendar_counter;

  logic        clk = 1'b0;
  logic        clear, tick, load, enable;
  logic [4:0]  ld_day;
  logic [3:0]  ld_month;
  logic [11:0] ld_year;
  logic [3:0]  ld_year4;
  logic [1:0]  sel;
  logic        kick = 1'b0;

  logic [4:0]  d0, d1, d2;
  logic [3:0]  m0, m1, m2;
  logic [11:0] y0, y1, b0, b1;
  logic [3:0]  y2, b2;
  logic        ny0, ny1, ny2, er0, er1, er2;

  always #5 clk = ~clk;

  calendar_counter #(.YEAR_W(12), .YEAR_INIT(2000), .LEAP_MODE(1)) u0 (
    .clk(clk), .clear(clear), .tick(tick), .load(load),
    .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year),
    .enable(enable), .sel(sel), .day(d0), .month(m0), .year(y0),
    .databus(b0), .new_year(ny0), .load_err(er0));

  calendar_counter #(.YEAR_W(12), .YEAR_INIT(2000), .LEAP_MODE(0)) u1 (
    .clk(clk), .clear(clear), .tick(tick), .load(load),
    .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year),
    .enable(enable), .sel(sel), .day(d1), .month(m1), .year(y1),
    .databus(b1), .new_year(ny1), .load_err(er1));

  calendar_counter #(.YEAR_W(4), .YEAR_INIT(0), .LEAP_MODE(1)) u2 (
    .clk(clk), .clear(clear), .tick(tick), .load(load),
    .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year4),
    .enable(enable), .sel(sel), .day(d2), .month(m2), .year(y2),
    .databus(b2), .new_year(ny2), .load_err(er2));

  typedef struct {
    int    dut;
    int    d;
    int    m;
    int    y;
    bit    ny;
    bit    err;
    string name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic drv(input bit t, input bit l,
                     input int dd, input int mm, input int yy);
    tick     = t;
    load     = l;
    ld_day   = 5'(dd);
    ld_month = 4'(mm);
    ld_year  = 12'(yy);
    ld_year4 = 4'(yy);
  endtask

  task automatic expect_st(input int dut, input int dd, input int mm,
                           input int yy, input bit ny, input bit err,
                           input string nm);
    exp_t e;
    e.dut = dut; e.d = dd; e.m = mm; e.y = yy;
    e.ny = ny; e.err = err; e.name = nm;
    q.push_back(e);
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic pulse_kick();
    kick = 1'b1;
    #2;
    kick = 1'b0;
  endtask

  // Monitor: outputs settle by posedge+1 (or kick+1 for async checks)
  always begin
    exp_t e;
    int ad, am, ay, ab, eb;
    bit an, ae, ok;
    @(posedge clk or posedge kick);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      ab = 0;
      case (e.dut)
        0: begin
          ad = int'(d0); am = int'(m0); ay = int'(y0);
          an = ny0; ae = er0; ab = int'(b0);
        end
        1: begin
          ad = int'(d1); am = int'(m1); ay = int'(y1);
          an = ny1; ae = er1;
        end
        default: begin
          ad = int'(d2); am = int'(m2); ay = int'(y2);
          an = ny2; ae = er2;
        end
      endcase
      eb = !enable ? 0 : (sel == 2'd0) ? e.d : (sel == 2'd1) ? e.m :
           (sel == 2'd2) ? e.y : 0;
      ok = (ad == e.d) && (am == e.m) && (ay == e.y) &&
           (an == e.ny) && (ae == e.err) &&
           ((e.dut != 0) || (ab == eb));
      n_checks++;
      if (!ok) begin
        n_err++;
        $display("FAIL %s dut%0d: got %0d/%0d/%0d ny=%0b err=%0b bus=%0d, want %0d/%0d/%0d ny=%0b err=%0b bus=%0d",
                 e.name, e.dut, ad, am, ay, an, ae, ab,
                 e.d, e.m, e.y, e.ny, e.err, eb);
      end
    end
  end

  initial begin
    clear = 1'b1; enable = 1'b1; sel = 2'd2;
    drv(0, 0, 0, 0, 0);
    expect_st(0, 1, 1, 2000, 0, 0, "reset");
    expect_st(2, 1, 1, 0, 0, 0, "reset_w4");
    nx();
    clear = 1'b0;
    nx();

    drv(0, 1, 31, 1, 2023); expect_st(0, 31, 1, 2023, 0, 0, "ld_jan31"); nx();
    drv(1, 0, 0, 0, 0);     expect_st(0, 1, 2, 2023, 0, 0, "tick_jan"); nx();
    drv(0, 1, 30, 4, 2023); expect_st(0, 30, 4, 2023, 0, 0, "ld_apr30"); nx();
    drv(1, 0, 0, 0, 0);     expect_st(0, 1, 5, 2023, 0, 0, "tick_apr"); nx();
    drv(0, 1, 28, 2, 2023); nx();
    drv(1, 0, 0, 0, 0);     expect_st(0, 1, 3, 2023, 0, 0, "feb_2023"); nx();

    drv(0, 1, 28, 2, 2024); nx();
    drv(1, 0, 0, 0, 0);     expect_st(0, 29, 2, 2024, 0, 0, "feb28_2024"); nx();
    drv(1, 0, 0, 0, 0);     expect_st(0, 1, 3, 2024, 0, 0, "feb29_2024"); nx();
    drv(0, 1, 28, 2, 1900); nx();
    drv(1, 0, 0, 0, 0);
    expect_st(0, 1, 3, 1900, 0, 0, "greg_1900");
    expect_st(1, 29, 2, 1900, 0, 0, "div4_1900");
    nx();
    drv(0, 1, 28, 2, 2000); nx();
    drv(1, 0, 0, 0, 0);     expect_st(0, 29, 2, 2000, 0, 0, "greg_2000"); nx();

    drv(0, 1, 31, 12, 2023); nx();
    drv(1, 0, 0, 0, 0);     expect_st(0, 1, 1, 2024, 1, 0, "rollover"); nx();
    drv(0, 0, 0, 0, 0);     expect_st(0, 1, 1, 2024, 0, 0, "ny_once"); nx();
    drv(0, 1, 31, 12, 15); nx();
    drv(1, 0, 0, 0, 0);     expect_st(2, 1, 1, 0, 1, 0, "wrap_w4"); nx();
    drv(0, 0, 0, 0, 0);     expect_st(2, 1, 1, 0, 0, 0, "wrap_w4_once"); nx();

    drv(0, 1, 10, 6, 2023); nx();
    drv(0, 1, 30, 2, 2024); expect_st(0, 10, 6, 2023, 0, 1, "rej_feb30"); nx();
    drv(0, 1, 29, 2, 2024); expect_st(0, 29, 2, 2024, 0, 0, "acc_feb29"); nx();
    drv(0, 1, 29, 2, 2023); expect_st(0, 29, 2, 2024, 0, 1, "rej_29_2023"); nx();
    drv(0, 1, 10, 6, 2023); expect_st(0, 10, 6, 2023, 0, 0, "acc_jun10"); nx();
    drv(0, 1, 1, 13, 2023); expect_st(0, 10, 6, 2023, 0, 1, "rej_m13"); nx();
    drv(0, 1, 10, 6, 2023); nx();
    drv(0, 1, 0, 5, 2023);  expect_st(0, 10, 6, 2023, 0, 1, "rej_d0"); nx();
    drv(0, 1, 10, 6, 2023); nx();
    drv(0, 1, 5, 0, 2023);  expect_st(0, 10, 6, 2023, 0, 1, "rej_m0"); nx();

    drv(0, 1, 31, 12, 2023); expect_st(0, 31, 12, 2023, 0, 0, "ld_dec31"); nx();
    drv(1, 1, 15, 7, 2030); expect_st(0, 15, 7, 2030, 0, 0, "ld_over_tick"); nx();
    drv(1, 1, 31, 4, 2030); expect_st(0, 15, 7, 2030, 0, 1, "rej_over_tick"); nx();

    drv(0, 1, 1, 1, 2023); nx();
    for (int i = 0; i < 100; i++) begin
      drv(1, 0, 0, 0, 0);
      if (i == 99) expect_st(0, 11, 4, 2023, 0, 0, "tick100");
      nx();
    end

    drv(1, 0, 0, 0, 0);
    #2;
    clear = 1'b1;
    expect_st(0, 1, 1, 2000, 0, 0, "async_clear");
    pulse_kick();
    nx();
    enable = 1'b0;
    #1; expect_st(0, 1, 1, 2000, 0, 0, "bus_en0"); pulse_kick();
    enable = 1'b1; sel = 2'd3;
    #1; expect_st(0, 1, 1, 2000, 0, 0, "bus_sel3"); pulse_kick();
    sel = 2'd1;
    #1; expect_st(0, 1, 1, 2000, 0, 0, "bus_month"); pulse_kick();
    nx();
    clear = 1'b0; sel = 2'd0;
    drv(1, 0, 0, 0, 0);     expect_st(0, 2, 1, 2000, 0, 0, "tick_after_clr"); nx();
    drv(0, 0, 0, 0, 0);

    for (int i = 0; i < 5 && q.size() > 0; i++) nx();
    if (q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
